imem_loader: RTL and testbench

//   Instruction memory for the 16-bit CPU, plus a byte-serial program loader. It

---
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: 64x16 instruction memory with a zero-latency fetch port and a
// byte-serial host loader (valid/ready) that holds the CPU while a load runs.
module imem_loader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 7
) (
  input  logic              clk_main,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] InstructIn,
  input  logic              ld_start,
  input  logic [CNT_W-1:0]  ld_count,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              cpu_hold,
  output logic              ld_done,
  output logic              ld_err
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {IDLE, HI, LO, WR, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_rem;
  logic [BYTE_W-1:0]   r_hi;
  logic [BYTE_W-1:0]   r_lo;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_cnt_ok;
  logic                w_start_ok;
  logic                w_xfer;
  logic                w_we;
  logic                w_err;
  logic                w_ready_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;

  assign w_cnt_ok = (ld_count != '0) && (ld_count <= CNT_W'(DEPTH));
  assign w_xfer   = ld_valid && r_ready;

  // Next-state decode; output flags are precomputed from the next state so
  // every handshake/status output comes straight from a flop.
  always_comb begin
    w_next      = r_state;
    w_start_ok  = 1'b0;
    w_err       = 1'b0;
    w_we        = 1'b0;
    case (r_state)
      IDLE: begin
        if (ld_start) begin
          if (w_cnt_ok) begin
            w_next     = HI;
            w_start_ok = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      HI:      if (w_xfer) w_next = LO;
      LO:      if (w_xfer) w_next = WR;
      WR: begin
        w_we   = 1'b1;
        w_next = (r_rem == CNT_W'(1)) ? DONE : HI;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    w_ready_nxt = (w_next == HI) || (w_next == LO);
    w_busy_nxt  = (w_next != IDLE);
    w_done_nxt  = (w_next == DONE);
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err;
    end
  end

  // Loader datapath: word address, remaining-word count and byte staging.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      if (w_start_ok) begin
        r_addr <= '0;
        r_rem  <= ld_count;
      end
      if ((r_state == HI) && w_xfer) r_hi <= ld_byte;
      if ((r_state == LO) && w_xfer) r_lo <= ld_byte;
      if (w_we) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_rem  <= r_rem - CNT_W'(1);
      end
    end
  end

  // Memory array has no reset so program contents survive a CPU reset.
  always_ff @(posedge clk_main) begin
    if (!reset && w_we) r_mem[r_addr] <= DATA_W'({r_hi, r_lo});
  end

  assign InstructIn = r_busy ? '0 : r_mem[PC];
  assign ld_ready   = r_ready;
  assign ld_busy    = r_busy;
  assign cpu_hold   = r_busy;
  assign ld_done    = r_done;
  assign ld_err     = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: start-validation vector table, a word
// scoreboard drained through the fetch port, and multi-cycle corner sequences.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned DEPTH  = 64;

  logic              clk_main = 1'b0;
  logic              reset    = 1'b1;
  logic [ADDR_W-1:0] PC       = '0;
  logic [DATA_W-1:0] InstructIn;
  logic              ld_start = 1'b0;
  logic [CNT_W-1:0]  ld_count = '0;
  logic [7:0]        ld_byte  = '0;
  logic              ld_valid = 1'b0;
  logic              ld_ready, ld_busy, cpu_hold, ld_done, ld_err;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_main(clk_main), .reset(reset), .PC(PC), .InstructIn(InstructIn),
    .ld_start(ld_start), .ld_count(ld_count), .ld_byte(ld_byte),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_busy(ld_busy),
    .cpu_hold(cpu_hold), .ld_done(ld_done), .ld_err(ld_err)
  );

  always #5 clk_main = ~clk_main;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int done_cyc = 0;
  int start_cyc = 0;

  always @(posedge clk_main) cyc++;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk_main) begin
    if (ld_done)  begin done_cnt++; done_cyc = cyc; end
    if (ld_err)   err_cnt++;
    if (ld_start) start_cyc = cyc;
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_t;
  sb_t               sb_q[$];
  logic [DATA_W-1:0] exp_mem [DEPTH];
  bit                known   [DEPTH];

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic             exp_err;
    logic             exp_busy;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_main);
    #1;
  endtask

  task automatic start_load(input int count);
    ld_count = CNT_W'(count);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic push_exp(input int addr, input logic [DATA_W-1:0] data);
    sb_t e;
    e.addr = ADDR_W'(addr);
    e.data = data;
    sb_q.push_back(e);
    exp_mem[addr] = data;
    known[addr]   = 1'b1;
  endtask

  // Offer one byte after 'gap' idle cycles; returns after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    ld_valid = 1'b0;
    repeat (gap) tick();
    ld_byte  = b;
    ld_valid = 1'b1;
    n = 0;
    while (!ld_ready && n < 20) begin
      tick();
      n++;
    end
    if (!ld_ready) begin
      chk("ready_timeout", 32'(ld_ready), 32'd1);
    end else begin
      tick();
    end
    ld_valid = 1'b0;
  endtask

  // Both bytes of a word; afterwards the loader sits in its write cycle.
  task automatic send_word(input int addr, input logic [DATA_W-1:0] data, input int gap);
    send_byte(data[15:8], gap);
    send_byte(data[7:0], gap);
    chk("ready_low_in_wr", 32'(ld_ready), 32'd0);
    chk("hold_in_wr", 32'(cpu_hold), 32'd1);
    chk("instr_forced_zero", 32'(InstructIn), 32'h0);
    push_exp(addr, data);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (ld_busy && n < 20) begin
      tick();
      n++;
    end
    if (ld_busy) chk("idle_timeout", 32'(ld_busy), 32'd0);
  endtask

  task automatic drain_sb();
    sb_t e;
    while (sb_q.size() > 0) begin
      e  = sb_q.pop_front();
      PC = e.addr;
      tick();
      chk("sb_word", 32'(InstructIn), 32'(e.data));
    end
  endtask

  task automatic full_sweep(input string name);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (known[i]) begin
        PC = ADDR_W'(i);
        tick();
        chk(name, 32'(InstructIn), 32'(exp_mem[i]));
      end
    end
  endtask

  initial begin
    int d0;
    int e0;
    logic [7:0] b;

    vecs[0] = '{count: 7'd0,   exp_err: 1'b1, exp_busy: 1'b0};
    vecs[1] = '{count: 7'd65,  exp_err: 1'b1, exp_busy: 1'b0};
    vecs[2] = '{count: 7'd127, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[3] = '{count: 7'd1,   exp_err: 1'b0, exp_busy: 1'b1};
    vecs[4] = '{count: 7'd64,  exp_err: 1'b0, exp_busy: 1'b1};
    for (int i = 0; i < int'(DEPTH); i++) known[i] = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_busy",  32'(ld_busy),  32'd0);
    chk("rst_hold",  32'(cpu_hold), 32'd0);
    chk("rst_done",  32'(ld_done),  32'd0);
    chk("rst_err",   32'(ld_err),   32'd0);
    reset = 1'b0;
    tick();

    // Two-word load with valid held high
    d0 = done_cnt;
    start_load(2);
    chk("t1_hold_hi", 32'(cpu_hold), 32'd1);
    chk("t1_instr_zero", 32'(InstructIn), 32'h0);
    send_word(0, 16'h1234, 0);
    send_word(1, 16'hABCD, 0);
    tick();
    chk("t1_done_pulse", 32'(ld_done), 32'd1);
    chk("t1_hold_done", 32'(cpu_hold), 32'd1);
    tick();
    chk("t1_done_end", 32'(ld_done), 32'd0);
    chk("t1_busy_end", 32'(ld_busy), 32'd0);
    chk("t1_done_count", 32'(done_cnt - d0), 32'd1);
    chk("t1_done_latency", 32'(done_cyc - start_cyc), 32'd7);
    PC = 6'd1;
    #1;
    chk("t1_fetch_same_cycle", 32'(InstructIn), 32'hABCD);
    drain_sb();

    // Start-validation table; accepted loads are aborted by reset
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      e0 = err_cnt;
      start_load(int'(vecs[i].count));
      chk("vec_err",   32'(ld_err),   32'(vecs[i].exp_err));
      chk("vec_busy",  32'(ld_busy),  32'(vecs[i].exp_busy));
      chk("vec_ready", 32'(ld_ready), 32'(vecs[i].exp_busy));
      tick();
      chk("vec_err_1cyc", 32'(ld_err), 32'd0);
      chk("vec_err_cnt", 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      if (ld_busy) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("vec_abort_busy", 32'(ld_busy), 32'd0);
      end
    end
    chk("vec_no_done", 32'(done_cnt - d0), 32'd0);
    full_sweep("t2_mem_unchanged");

    // Full 64-word load with random valid gaps
    d0 = done_cnt;
    start_load(64);
    for (int i = 0; i < int'(DEPTH); i++) begin
      b = 8'(i);
      send_word(i, {b, b}, int'($urandom_range(0, 3)));
    end
    wait_idle();
    chk("t3_done_count", 32'(done_cnt - d0), 32'd1);
    drain_sb();

    // Reset after the third byte of a three-word load
    d0 = done_cnt;
    start_load(3);
    send_word(0, 16'h1122, 0);
    send_byte(8'h33, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_busy",  32'(ld_busy),  32'd0);
    chk("t4_hold",  32'(cpu_hold), 32'd0);
    chk("t4_ready", 32'(ld_ready), 32'd0);
    tick();
    chk("t4_still_idle", 32'(ld_busy), 32'd0);
    chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
    drain_sb();
    full_sweep("t4_mem");

    // Reset and ld_start in the same cycle
    reset    = 1'b1;
    ld_count = 7'd1;
    ld_start = 1'b1;
    tick();
    reset    = 1'b0;
    ld_start = 1'b0;
    chk("rst_start_busy", 32'(ld_busy), 32'd0);
    tick();
    chk("rst_start_busy2", 32'(ld_busy), 32'd0);

    // Valid in IDLE and ld_start mid-load are ignored
    d0 = done_cnt;
    e0 = err_cnt;
    ld_byte  = 8'hFF;
    ld_valid = 1'b1;
    repeat (3) tick();
    chk("t5_idle_ready", 32'(ld_ready), 32'd0);
    chk("t5_idle_busy",  32'(ld_busy),  32'd0);
    ld_valid = 1'b0;
    start_load(2);
    send_byte(8'h5A, 0);
    start_load(1);
    chk("t5_still_busy", 32'(ld_busy), 32'd1);
    send_byte(8'hC3, 1);
    push_exp(0, 16'h5AC3);
    send_word(1, 16'h0F0F, 1);
    wait_idle();
    chk("t5_done_count", 32'(done_cnt - d0), 32'd1);
    chk("t5_no_err", 32'(err_cnt - e0), 32'd0);
    drain_sb();
    full_sweep("final_mem");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
